// File: rtl/bespoke_pkg.sv
// Shared element type and sizing helper for the ping-pong vector buffer.
package bespoke_pkg;

  typedef logic signed [7:0] elem_t;

  localparam int unsigned ElemW = 8;

  function automatic int unsigned chunks_f(input int unsigned vec_length,
                                           input int unsigned read_regs);
    return vec_length / read_regs;
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One vector bank: element-indexed write port, chunk-indexed combinational read port.
module vec_bank
  import bespoke_pkg::*;
#(
  parameter int unsigned VecLength = 16,
  parameter int unsigned ReadRegs  = 4,
  localparam int unsigned Chunks   = chunks_f(VecLength, ReadRegs),
  localparam int unsigned IdxW     = (VecLength > 1) ? $clog2(VecLength) : 1,
  localparam int unsigned ChunkW   = (Chunks > 1) ? $clog2(Chunks) : 1
) (
  input  logic                      clk_in,
  input  logic                      i_we,
  input  logic [IdxW-1:0]           i_idx,
  input  elem_t                     i_data,
  input  logic [ChunkW-1:0]         i_chunk,
  output logic [ReadRegs*ElemW-1:0] o_chunk
);

  // Storage is deliberately unreset; validity is tracked by the owner's full flags.
  elem_t r_mem [VecLength];

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  always_comb begin
    o_chunk = '0;
    for (int l = 0; l < ReadRegs; l++) begin
      o_chunk[l*ElemW +: ElemW] = r_mem[IdxW'(32'(i_chunk) * ReadRegs + 32'(l))];
    end
  end

endmodule

// File: rtl/vec_chunk_buffer.sv
// Ping-pong vector store: serial element fill on one bank, chunked re-reads from the other.
module vec_chunk_buffer
  import bespoke_pkg::*;
#(
  parameter int unsigned VecLength = 16,
  parameter int unsigned ReadRegs  = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_valid,
  input  elem_t                     wr_data,
  input  logic                      rd_chunk_next,
  input  logic                      rd_ptr_rst,
  input  logic                      rd_release,
  output logic [ReadRegs*ElemW-1:0] rd_data,
  output logic                      rd_ready,
  output logic                      wr_full,
  output logic                      overflow
);

  localparam int unsigned Chunks = chunks_f(VecLength, ReadRegs);
  localparam int unsigned IdxW   = (VecLength > 1) ? $clog2(VecLength) : 1;
  localparam int unsigned ChunkW = (Chunks > 1) ? $clog2(Chunks) : 1;

  if (VecLength % ReadRegs != 0) begin : g_bad_geometry
    $error("VecLength must be a multiple of ReadRegs");
  end

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [IdxW-1:0]   r_wr_cnt;
  logic [ChunkW-1:0] r_rd_ptr;
  logic              r_overflow;

  logic                      w_accept;
  logic                      w_wr_last;
  logic                      w_release;
  logic [1:0]                w_we;
  logic [1:0]                w_full_d;
  logic [ReadRegs*ElemW-1:0] w_chunk [2];

  // Admission looks only at registered state, so a same-cycle release never frees a slot.
  always_comb begin
    w_accept  = wr_valid & ~r_full[r_wr_bank];
    w_wr_last = w_accept & (r_wr_cnt == IdxW'(VecLength - 1));
    w_release = rd_release & rd_ready;
    w_we      = '0;
    w_we[r_wr_bank] = w_accept;
    // Completion and release can never target the same bank.
    w_full_d  = r_full;
    if (w_release) w_full_d[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_d[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_full     <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_d;
      if (w_accept) begin
        r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + IdxW'(1);
      end
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (wr_valid && !w_accept) begin
        r_overflow <= 1'b1;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_ptr  <= '0;
      end else if (rd_ready) begin
        if (rd_ptr_rst) begin
          r_rd_ptr <= '0;
        end else if (rd_chunk_next) begin
          r_rd_ptr <= (r_rd_ptr == ChunkW'(Chunks - 1)) ? '0 : r_rd_ptr + ChunkW'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vec_bank #(
      .VecLength(VecLength),
      .ReadRegs (ReadRegs)
    ) u_bank (
      .clk_in (clk_in),
      .i_we   (w_we[b]),
      .i_idx  (r_wr_cnt),
      .i_data (wr_data),
      .i_chunk(r_rd_ptr),
      .o_chunk(w_chunk[b])
    );
  end

  always_comb begin
    rd_ready = r_full[r_rd_bank];
    wr_full  = r_full[0] & r_full[1];
    overflow = r_overflow;
    rd_data  = rd_ready ? w_chunk[r_rd_bank] : '0;
  end

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// Directed self-checking bench for vec_chunk_buffer with VecLength=8, ReadRegs=4.
module tb_vec_chunk_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        rd_chunk_next;
  logic        rd_ptr_rst;
  logic        rd_release;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        wr_full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  vec_chunk_buffer #(
    .VecLength(8),
    .ReadRegs (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .rd_chunk_next(rd_chunk_next),
    .rd_ptr_rst   (rd_ptr_rst),
    .rd_release   (rd_release),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .wr_full      (wr_full),
    .overflow     (overflow)
  );

  // Stimulus helpers: each spans one rising edge and returns 1ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
    wr_valid      = 1'b0;
    rd_chunk_next = 1'b0;
    rd_ptr_rst    = 1'b0;
    rd_release    = 1'b0;
    rst_in        = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    step();
  endtask

  task automatic push_vec(input logic [7:0] first);
    for (int i = 0; i < 8; i++) push(first + 8'(i));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    wr_valid = 0; wr_data = 0; rd_chunk_next = 0; rd_ptr_rst = 0; rd_release = 0;
    do_reset();
    do_reset();
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
    checks++;
    if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %b exp 0", wr_full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
  endtask

  task automatic test_fill_and_wrap();
    for (int i = 1; i <= 7; i++) push(8'(i));
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL fill_early_ready got %b exp 0", rd_ready); end
    push(8'd8);
    checks++;
    if (rd_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b exp 1", rd_ready); end
    checks++;
    if (rd_data !== 32'h04030201) begin errors++; $display("FAIL fill_chunk0 got %h exp 04030201", rd_data); end
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h08070605) begin errors++; $display("FAIL fill_chunk1 got %h exp 08070605", rd_data); end
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h04030201) begin errors++; $display("FAIL fill_wrap got %h exp 04030201", rd_data); end
  endtask

  task automatic test_ptr_rst_priority();
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h08070605) begin errors++; $display("FAIL prio_setup got %h exp 08070605", rd_data); end
    rd_chunk_next = 1'b1; rd_ptr_rst = 1'b1; step();
    checks++;
    if (rd_data !== 32'h04030201) begin errors++; $display("FAIL prio_rewind got %h exp 04030201", rd_data); end
    rd_release = 1'b1; step();
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL release_ready got %b exp 0", rd_ready); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL release_data got %h exp 0", rd_data); end
  endtask

  task automatic test_overflow();
    push_vec(8'd1);
    push_vec(8'd11);
    checks++;
    if (wr_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", wr_full); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    checks++;
    if (rd_data !== 32'h04030201) begin errors++; $display("FAIL ovf_first got %h exp 04030201", rd_data); end
    push(8'd99);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    rd_release = 1'b1; step();
    checks++;
    if (rd_data !== 32'h0E0D0C0B) begin errors++; $display("FAIL ovf_second got %h exp 0E0D0C0B", rd_data); end
    checks++;
    if (wr_full !== 1'b0) begin errors++; $display("FAIL ovf_unfull got %b exp 0", wr_full); end
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h1211100F) begin errors++; $display("FAIL ovf_not_stored got %h exp 1211100F", rd_data); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    rd_release = 1'b1; step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    push_vec(8'd21);
    checks++;
    if (rd_data !== 32'h18171615) begin errors++; $display("FAIL b2b_a0 got %h exp 18171615", rd_data); end
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1; wr_data = 8'(31 + k); rd_chunk_next = 1'b1;
      step();
      exp = (k % 2 == 0) ? 32'h1C1B1A19 : 32'h18171615;
      checks++;
      if (rd_data !== exp) begin
        errors++; $display("FAIL b2b_reread_%0d got %h exp %h", k, rd_data, exp);
      end
    end
    checks++;
    if (wr_full !== 1'b1) begin errors++; $display("FAIL b2b_full got %b exp 1", wr_full); end
    rd_release = 1'b1; step();
    checks++;
    if (rd_data !== 32'h2221201F) begin errors++; $display("FAIL b2b_b0 got %h exp 2221201F", rd_data); end
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h26252423) begin errors++; $display("FAIL b2b_b1 got %h exp 26252423", rd_data); end
  endtask

  task automatic test_idle_requests();
    do_reset();
    rd_release = 1'b1; rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", rd_ready); end
    checks++;
    if (rd_data !== 32'h0) begin errors++; $display("FAIL idle_data got %h exp 0", rd_data); end
    push_vec(8'd41);
    checks++;
    if (rd_ready !== 1'b1) begin errors++; $display("FAIL idle_then_ready got %b exp 1", rd_ready); end
    checks++;
    if (rd_data !== 32'h2C2B2A29) begin errors++; $display("FAIL idle_then_chunk0 got %h exp 2C2B2A29", rd_data); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(8'(61 + i));
    do_reset();
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", rd_ready); end
    checks++;
    if (wr_full !== 1'b0) begin errors++; $display("FAIL midrst_full got %b exp 0", wr_full); end
    for (int i = 0; i < 7; i++) push(8'(51 + i));
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL midrst_early got %b exp 0", rd_ready); end
    push(8'd58);
    checks++;
    if (rd_data !== 32'h36353433) begin errors++; $display("FAIL midrst_chunk0 got %h exp 36353433", rd_data); end
    rd_chunk_next = 1'b1; step();
    checks++;
    if (rd_data !== 32'h3A393837) begin errors++; $display("FAIL midrst_chunk1 got %h exp 3A393837", rd_data); end
  endtask

  initial begin
    rst_in = 1'b1;
    test_reset();
    test_fill_and_wrap();
    test_ptr_rst_priority();
    test_overflow();
    test_back_to_back();
    test_idle_requests();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
